// File: rtl/tx_queue_fetcher.sv
// TX ring consumer: turns doorbell-advanced [head, tail) spans into bounded DMA read
// requests with wrap at rb_size, then publishes the new head.
package tx_queue_fetcher_pkg;
    localparam int RB_AWIDTH = 26;
endpackage

module tx_queue_fetcher
    import tx_queue_fetcher_pkg::*;
#(
    parameter int NB_QUEUES      = 64,
    parameter int QUEUE_ID_WIDTH = $clog2(NB_QUEUES),
    parameter int MAX_REQ_FLITS  = 64,
    localparam int FW            = $clog2(MAX_REQ_FLITS) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [QUEUE_ID_WIDTH-1:0] in_queue_id,
    input  logic [RB_AWIDTH-1:0]      in_tail,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      addr_rd_en,
    output logic [QUEUE_ID_WIDTH-1:0] addr_rd_queue,
    input  logic [63:0]               addr_rd_data,
    output logic [63:0]               out_req_addr,
    output logic [FW-1:0]             out_req_flits,
    output logic [QUEUE_ID_WIDTH-1:0] out_req_queue,
    output logic                      out_req_valid,
    input  logic                      out_req_ready,
    output logic [QUEUE_ID_WIDTH-1:0] out_head_queue,
    output logic [RB_AWIDTH-1:0]      out_head,
    output logic                      out_head_valid,
    output logic                      out_err,
    input  logic [RB_AWIDTH-1:0]      rb_size,
    output logic [2:0]                fsm_state
);

    // Handshakes: a doorbell transfers when in_valid & in_ready at a rising edge; a request
    // transfers when out_req_valid & out_req_ready, and its fields hold until that edge.
    typedef enum logic [2:0] {IDLE, FETCH, WAIT1, WAIT2, ISSUE, UPDATE} state_t;

    state_t                    state;
    logic [QUEUE_ID_WIDTH-1:0] cur_q;
    logic [RB_AWIDTH-1:0]      cur_tail;
    logic [RB_AWIDTH-1:0]      cur_head;
    logic [63:0]               base;
    logic [RB_AWIDTH-1:0]      head_tbl [NB_QUEUES];

    logic                      accept;
    logic                      req_fire;
    logic [RB_AWIDTH:0]        head_sum;
    logic [RB_AWIDTH-1:0]      next_head;

    // Flits available before either the tail or the end of the ring, capped at one request.
    function automatic logic [FW-1:0] chunk_of(input logic [RB_AWIDTH-1:0] h,
                                               input logic [RB_AWIDTH-1:0] t,
                                               input logic [RB_AWIDTH-1:0] sz);
        logic [RB_AWIDTH-1:0] avail;
        avail = (h < t) ? (t - h) : (sz - h);
        if (avail >= RB_AWIDTH'(MAX_REQ_FLITS))
            return FW'(MAX_REQ_FLITS);
        return FW'(avail);
    endfunction

    assign in_ready  = rst && (state == IDLE);
    assign fsm_state = state;

    always_comb begin
        accept    = in_valid && in_ready;
        req_fire  = out_req_valid && out_req_ready;
        head_sum  = {1'b0, cur_head} + (RB_AWIDTH + 1)'(out_req_flits);
        next_head = (head_sum == {1'b0, rb_size}) ? '0 : head_sum[RB_AWIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cur_q          <= '0;
            cur_tail       <= '0;
            cur_head       <= '0;
            base           <= '0;
            addr_rd_en     <= 1'b0;
            addr_rd_queue  <= '0;
            out_req_addr   <= '0;
            out_req_flits  <= '0;
            out_req_queue  <= '0;
            out_req_valid  <= 1'b0;
            out_head_queue <= '0;
            out_head       <= '0;
            out_head_valid <= 1'b0;
            out_err        <= 1'b0;
            for (int i = 0; i < NB_QUEUES; i++)
                head_tbl[i] <= '0;
        end else begin
            out_err        <= 1'b0;
            out_head_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_tail >= rb_size) begin
                            out_err <= 1'b1;
                        end else if (in_tail != head_tbl[in_queue_id]) begin
                            cur_q         <= in_queue_id;
                            cur_tail      <= in_tail;
                            cur_head      <= head_tbl[in_queue_id];
                            addr_rd_en    <= 1'b1;
                            addr_rd_queue <= in_queue_id;
                            state         <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    addr_rd_en <= 1'b0;
                    state      <= WAIT1;
                end
                WAIT1: state <= WAIT2;
                WAIT2: begin
                    base          <= addr_rd_data;
                    out_req_addr  <= addr_rd_data + ({{(64-RB_AWIDTH){1'b0}}, cur_head} << 6);
                    out_req_flits <= chunk_of(cur_head, cur_tail, rb_size);
                    out_req_queue <= cur_q;
                    out_req_valid <= 1'b1;
                    state         <= ISSUE;
                end
                ISSUE: begin
                    if (req_fire) begin
                        cur_head <= next_head;
                        if (next_head == cur_tail) begin
                            out_req_valid  <= 1'b0;
                            out_head_valid <= 1'b1;
                            out_head_queue <= cur_q;
                            out_head       <= cur_tail;
                            state          <= UPDATE;
                        end else begin
                            out_req_addr  <= base + ({{(64-RB_AWIDTH){1'b0}}, next_head} << 6);
                            out_req_flits <= chunk_of(next_head, cur_tail, rb_size);
                        end
                    end
                end
                UPDATE: begin
                    head_tbl[cur_q] <= cur_tail;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_queue_fetcher.sv
// Scoreboard bench for tx_queue_fetcher: directed doorbells, expected requests/head
// updates queued at issue time and popped by an independent monitor.
module tb_tx_queue_fetcher;

    localparam int QW = 6;
    localparam int FW = 7;
    localparam int AW = 26;

    logic          clk;
    logic          rst;
    logic [QW-1:0] in_queue_id;
    logic [AW-1:0] in_tail;
    logic          in_valid;
    logic          in_ready;
    logic          addr_rd_en;
    logic [QW-1:0] addr_rd_queue;
    logic [63:0]   addr_rd_data;
    logic [63:0]   out_req_addr;
    logic [FW-1:0] out_req_flits;
    logic [QW-1:0] out_req_queue;
    logic          out_req_valid;
    logic          out_req_ready;
    logic [QW-1:0] out_head_queue;
    logic [AW-1:0] out_head;
    logic          out_head_valid;
    logic          out_err;
    logic [AW-1:0] rb_size;
    logic [2:0]    fsm_state;

    tx_queue_fetcher dut (
        .clk(clk), .rst(rst),
        .in_queue_id(in_queue_id), .in_tail(in_tail), .in_valid(in_valid), .in_ready(in_ready),
        .addr_rd_en(addr_rd_en), .addr_rd_queue(addr_rd_queue), .addr_rd_data(addr_rd_data),
        .out_req_addr(out_req_addr), .out_req_flits(out_req_flits), .out_req_queue(out_req_queue),
        .out_req_valid(out_req_valid), .out_req_ready(out_req_ready),
        .out_head_queue(out_head_queue), .out_head(out_head), .out_head_valid(out_head_valid),
        .out_err(out_err), .rb_size(rb_size), .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // buffer-address table with a two-cycle read latency; garbage outside the valid slot
    logic [63:0]   base_tbl [64];
    logic          en1, en2;
    logic [QW-1:0] rq1, rq2;
    always @(posedge clk) begin
        en1 <= addr_rd_en;
        en2 <= en1;
        rq1 <= addr_rd_queue;
        rq2 <= rq1;
    end
    assign addr_rd_data = en2 ? base_tbl[rq2] : 64'hDEAD_BEEF_DEAD_BEEF;

    // scoreboard
    logic [76:0] exp_req_q[$];
    logic [31:0] exp_head_q[$];
    int          checks = 0;
    int          errors = 0;
    int          err_exp = 0;
    int          rd_en_exp = 0;
    int          rd_en_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [63:0] a, input int f, input int q);
        exp_req_q.push_back({a, FW'(f), QW'(q)});
    endtask

    task automatic push_head(input int q, input int h);
        exp_head_q.push_back({QW'(q), AW'(h)});
    endtask

    // monitor
    logic [76:0] e_req;
    logic [31:0] e_head;
    logic        prev_stall = 1'b0;
    logic [76:0] prev_fields;
    always @(negedge clk) begin
        if (rst) begin
            if (addr_rd_en) rd_en_seen++;
            if (prev_stall) begin
                checks++;
                if (!out_req_valid || {out_req_addr, out_req_flits, out_req_queue} !== prev_fields) begin
                    errors++;
                    $display("FAIL req_stable: got valid=%0b fields=0x%0h expected 0x%0h", out_req_valid,
                             {out_req_addr, out_req_flits, out_req_queue}, prev_fields);
                end
            end
            prev_stall  = out_req_valid && !out_req_ready;
            prev_fields = {out_req_addr, out_req_flits, out_req_queue};
            if (out_req_valid && out_req_ready) begin
                checks++;
                if (exp_req_q.size() == 0) begin
                    errors++;
                    $display("FAIL req_unexpected: got addr=0x%0h flits=%0d q=%0d expected none",
                             out_req_addr, out_req_flits, out_req_queue);
                end else begin
                    e_req = exp_req_q.pop_front();
                    if ({out_req_addr, out_req_flits, out_req_queue} !== e_req) begin
                        errors++;
                        $display("FAIL req: got addr=0x%0h flits=%0d q=%0d expected addr=0x%0h flits=%0d q=%0d",
                                 out_req_addr, out_req_flits, out_req_queue,
                                 e_req[76:13], e_req[12:6], e_req[5:0]);
                    end
                end
            end
            if (out_head_valid) begin
                checks++;
                if (exp_head_q.size() == 0) begin
                    errors++;
                    $display("FAIL head_unexpected: got q=%0d head=%0d expected none", out_head_queue, out_head);
                end else begin
                    e_head = exp_head_q.pop_front();
                    if ({out_head_queue, out_head} !== e_head) begin
                        errors++;
                        $display("FAIL head: got q=%0d head=%0d expected q=%0d head=%0d",
                                 out_head_queue, out_head, e_head[31:26], e_head[25:0]);
                    end
                end
            end
            if (out_err) begin
                checks++;
                if (err_exp == 0) begin
                    errors++;
                    $display("FAIL err_unexpected: got out_err=1 expected 0");
                end else begin
                    err_exp--;
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // driver tasks
    task automatic send_db(input int q, input int t);
        int n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) chk("db_ready_timeout", 64'(in_ready), 64'd1);
        in_queue_id = QW'(q);
        in_tail     = AW'(t);
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_req_q.size() == 0 && exp_head_q.size() == 0 && in_ready) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) chk("idle_timeout", 64'(exp_req_q.size() + exp_head_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_req_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("valid_timeout", 64'(out_req_valid), 64'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_addr_rd_en"}, 64'(addr_rd_en), 64'd0);
        chk({tag, "_req_valid"}, 64'(out_req_valid), 64'd0);
        chk({tag, "_req_addr"}, out_req_addr, 64'd0);
        chk({tag, "_req_flits"}, 64'(out_req_flits), 64'd0);
        chk({tag, "_head_valid"}, 64'(out_head_valid), 64'd0);
        chk({tag, "_err"}, 64'(out_err), 64'd0);
    endtask

    // stimulus
    initial begin
        for (int i = 0; i < 64; i++) base_tbl[i] = 64'hBAD0_0000_0000_0000 + 64'(i);
        base_tbl[3] = 64'h1000_0000;
        base_tbl[5] = 64'h2000_0000;
        base_tbl[7] = 64'h3000_0000;
        rst = 1'b0; in_valid = 1'b0; in_queue_id = '0; in_tail = '0;
        out_req_ready = 1'b1; rb_size = 26'd1024;
        #3;
        chk_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("ready_after_release", 64'(in_ready), 64'd1);

        // single short span with cycle-exact latency
        push_req(64'h1000_0000, 10, 3); push_head(3, 10); rd_en_exp++;
        send_db(3, 10);
        chk("lat_c1_rd_en", 64'(addr_rd_en), 64'd1);
        chk("lat_c1_rd_queue", 64'(addr_rd_queue), 64'd3);
        @(posedge clk); #1 chk("lat_c2_rd_en", 64'(addr_rd_en), 64'd0);
        @(posedge clk); #1 chk("lat_c3_valid", 64'(out_req_valid), 64'd0);
        @(posedge clk); #1 chk("lat_c4_valid", 64'(out_req_valid), 64'd1);
        @(posedge clk); #1 chk("lat_c5_head_valid", 64'(out_head_valid), 64'd1);
        chk("lat_c5_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1 chk("lat_c6_in_ready", 64'(in_ready), 64'd1);
        wait_idle();

        // multi-chunk span
        push_req(64'h1000_0280, 64, 3); push_req(64'h1000_1280, 64, 3);
        push_req(64'h1000_2280, 64, 3); push_req(64'h1000_3280, 8, 3);
        push_head(3, 210); rd_en_exp++;
        send_db(3, 210);
        wait_idle();

        // 210 -> 1020: twelve 64-flit chunks then 42
        for (int k = 0; k < 12; k++) push_req(64'h1000_0000 + 64'((210 + 64 * k) * 64), 64, 3);
        push_req(64'h1000_0000 + 64'(978 * 64), 42, 3);
        push_head(3, 1020); rd_en_exp++;
        send_db(3, 1020);
        wait_idle();

        // wrap: 1020 -> 4
        push_req(64'h1000_FF00, 4, 3); push_req(64'h1000_0000, 4, 3);
        push_head(3, 4); rd_en_exp++;
        send_db(3, 4);
        wait_idle();

        // tail == head: dropped silently
        send_db(3, 4);
        for (int i = 0; i < 6; i++) begin
            chk("drop_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
        end
        chk("drop_rd_en_count", 64'(rd_en_seen), 64'(rd_en_exp));

        // tail == rb_size: rejected
        err_exp++;
        send_db(3, 1024);
        chk("err_pulse", 64'(out_err), 64'd1);
        @(posedge clk); #1 chk("err_one_cycle", 64'(out_err), 64'd0);
        chk("err_seen", 64'(err_exp), 64'd0);
        push_req(64'h1000_0100, 1, 3); push_head(3, 5); rd_en_exp++;
        send_db(3, 5);
        wait_idle();

        // backpressure mid-span
        push_req(64'h2000_0000, 64, 5); push_req(64'h2000_1000, 64, 5);
        push_req(64'h2000_2000, 64, 5); push_req(64'h2000_3000, 8, 5);
        push_head(5, 200); rd_en_exp++;
        out_req_ready = 1'b0;
        send_db(5, 200);
        wait_valid();
        out_req_ready = 1'b1;
        @(posedge clk); #1;
        out_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_valid", 64'(out_req_valid), 64'd1);
        end
        chk("stall_pending", 64'(exp_req_q.size()), 64'd3);
        out_req_ready = 1'b1;
        wait_idle();

        // asynchronous reset during ISSUE
        out_req_ready = 1'b0;
        rd_en_exp++;
        send_db(7, 100);
        wait_valid();
        @(posedge clk); #2;
        rst = 1'b0;
        #1 chk_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("ready_after_midreset", 64'(in_ready), 64'd1);
        out_req_ready = 1'b1;
        push_req(64'h1000_0000, 3, 3); push_head(3, 3); rd_en_exp++;
        send_db(3, 3);
        wait_idle();
        push_req(64'h3000_0000, 2, 7); push_head(7, 2); rd_en_exp++;
        send_db(7, 2);
        wait_idle();

        chk("final_rd_en_count", 64'(rd_en_seen), 64'(rd_en_exp));
        chk("final_req_q_empty", 64'(exp_req_q.size()), 64'd0);
        chk("final_head_q_empty", 64'(exp_head_q.size()), 64'd0);
        chk("final_err_pending", 64'(err_exp), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
